instr_mem_fetch: RTL and testbench

//  Parametrised instruction memory with a registered valid/ready fetch port.

---
 rtl/instr_mem_fetch_pkg.sv | 23 ++
 rtl/instr_mem_fetch_if.sv | 41 ++++
 rtl/instr_mem_fetch_rsp_fifo.sv | 83 ++++++++
 rtl/instr_mem_fetch.sv | 93 +++++++++
 tb/tb_instr_mem_fetch.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_fetch_pkg.sv
// Shared constants and helpers for the instruction memory fetch block.
// Holds the NOP encoding, error-bit positions and the address checker.
package riscv_imem_pkg;

   localparam logic [31:0] RV_NOP = 32'h0000_0013;

   localparam int ERR_MISALIGN = 0;
   localparam int ERR_RANGE    = 1;
   localparam int ERR_W        = 2;

   // Error bits for a byte address against a memory of depth words.
   function automatic logic [ERR_W-1:0] addr_err(
      input logic [31:0] addr,
      input logic [29:0] depth
   );
      logic [ERR_W-1:0] e;
      e               = '0;
      e[ERR_MISALIGN] = |addr[1:0];
      e[ERR_RANGE]    = (addr[31:2] >= depth);
      return e;
   endfunction

endpackage

// File: rtl/instr_mem_fetch_if.sv
// Fetch request / response handshake bundle between fetch and decode.
// master = requester/consumer side, slave = instruction memory side.
interface instr_mem_fetch_if
   import riscv_imem_pkg::*;
#(
   parameter int XLEN = 32
);

   logic             req_valid;
   logic             req_ready;
   logic [31:0]      req_addr;

   logic             rsp_valid;
   logic             rsp_ready;
   logic [XLEN-1:0]  rsp_instr;
   logic [31:0]      rsp_addr;
   logic [ERR_W-1:0] rsp_err;

   modport master (
      output req_valid,
      output req_addr,
      output rsp_ready,
      input  req_ready,
      input  rsp_valid,
      input  rsp_instr,
      input  rsp_addr,
      input  rsp_err
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      input  rsp_ready,
      output req_ready,
      output rsp_valid,
      output rsp_instr,
      output rsp_addr,
      output rsp_err
   );

endinterface

// File: rtl/instr_mem_fetch_rsp_fifo.sv
// imem_rsp_fifo: 2-entry response FIFO with a registered head entry.
// Ports: clk/rst_n, push/pop/flush controls, in_* entry, head_* entry,
// valid (head present) and count (0..2).
module imem_rsp_fifo
   import riscv_imem_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [XLEN-1:0]  in_instr,
   input  logic [31:0]      in_addr,
   input  logic [ERR_W-1:0] in_err,
   output logic             valid,
   output logic [XLEN-1:0]  head_instr,
   output logic [31:0]      head_addr,
   output logic [ERR_W-1:0] head_err,
   output logic [1:0]       count
);

   localparam int EW = XLEN + 32 + ERR_W;

   logic [EW-1:0] head_q, head_d;
   logic [EW-1:0] tail_q, tail_d;
   logic [1:0]    count_q, count_d;
   logic [EW-1:0] din;
   logic          do_pop;
   logic          do_push;

   assign din     = {in_instr, in_addr, in_err};
   assign do_pop  = pop && (count_q != 2'd0);
   assign do_push = push && ((count_q != 2'd2) || do_pop);

   // The head register is the output; it is only overwritten when a new
   // entry moves into it, so an empty FIFO keeps showing the last head.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         count_d = 2'd0;
      end else if (do_push && do_pop) begin
         if (count_q == 2'd1) begin
            head_d = din;
         end else begin
            head_d = tail_q;
            tail_d = din;
         end
      end else if (do_push) begin
         if (count_q == 2'd0) begin
            head_d = din;
         end else begin
            tail_d = din;
         end
         count_d = count_q + 2'd1;
      end else if (do_pop) begin
         if (count_q == 2'd2) begin
            head_d = tail_q;
         end
         count_d = count_q - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= 2'd0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   assign valid = (count_q != 2'd0);
   assign count = count_q;
   assign {head_instr, head_addr, head_err} = head_q;

endmodule

// File: rtl/instr_mem_fetch.sv
// instr_mem_fetch: synchronous instruction memory with a valid/ready fetch
// port, 2-entry response buffer, flush, program-load port and error flags.
// Ports: clk, rst_n, flush, bus (slave: req_*/rsp_*), ld_en/ld_addr/ld_data
// (program-load write; the image is written through this port), fetch_cnt.
module instr_mem_fetch
   import riscv_imem_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   instr_mem_fetch_if.slave bus,
   input  logic            ld_en,
   input  logic [AW-1:0]   ld_addr,
   input  logic [XLEN-1:0] ld_data,
   output logic [31:0]     fetch_cnt
);

   localparam logic [29:0] DEPTH_W = 30'(DEPTH);
   localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

   logic [XLEN-1:0] mem_q [DEPTH];

   logic [31:0]      fetch_cnt_q, fetch_cnt_d;
   logic [AW-1:0]    word;
   logic [ERR_W-1:0] err;
   logic             ld_ok;
   logic             accept;
   logic             rsp_pop;
   logic [XLEN-1:0]  rd_data;
   logic [XLEN-1:0]  push_instr;
   logic [1:0]       count;

   assign word  = bus.req_addr[AW+1:2];
   assign err   = addr_err(bus.req_addr, DEPTH_W);
   assign ld_ok = ld_en && ({1'b0, ld_addr} < DEPTH_L);

   // Ready depends only on buffer fill and flush, never on rsp_ready.
   assign bus.req_ready = (count != 2'd2) && !flush;
   assign accept        = bus.req_valid && bus.req_ready;
   assign rsp_pop       = bus.rsp_valid && bus.rsp_ready;

   // Write-first bypass: a same-cycle load to the fetched word wins.
   always_comb begin
      rd_data = mem_q[word];
      if (ld_ok && (ld_addr == word)) begin
         rd_data = ld_data;
      end
   end

   assign push_instr = (|err) ? XLEN'(RV_NOP) : rd_data;

   // Program image storage; deliberately not reset.
   always_ff @(posedge clk) begin
      if (ld_ok) begin
         mem_q[ld_addr] <= ld_data;
      end
   end

   assign fetch_cnt_d = accept ? fetch_cnt_q + 32'd1 : fetch_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_q <= 32'd0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   assign fetch_cnt = fetch_cnt_q;

   imem_rsp_fifo #(
      .XLEN (XLEN)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (accept),
      .pop        (rsp_pop),
      .flush      (flush),
      .in_instr   (push_instr),
      .in_addr    (bus.req_addr),
      .in_err     (err),
      .valid      (bus.rsp_valid),
      .head_instr (bus.rsp_instr),
      .head_addr  (bus.rsp_addr),
      .head_err   (bus.rsp_err),
      .count      (count)
   );

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Randomised scoreboard bench for instr_mem_fetch.
// Driver pushes expected responses; a negedge monitor pops and compares.
module tb_instr_mem_fetch;

   localparam int DEPTH = 200;
   localparam int AW    = $clog2(DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] addr;
      logic [1:0]  err;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          flush;
   logic          ld_en;
   logic [AW-1:0] ld_addr;
   logic [31:0]   ld_data;
   logic [31:0]   fetch_cnt;

   instr_mem_fetch_if #(.XLEN(32)) bus ();

   instr_mem_fetch #(
      .XLEN  (32),
      .DEPTH (DEPTH)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .bus       (bus),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .fetch_cnt (fetch_cnt)
   );

   always #5 clk = ~clk;

   ent_t        q[$];
   logic [31:0] mm [DEPTH];
   logic [31:0] cnt_model;
   logic        exp_ready;
   logic        exp_valid;
   logic [31:0] exp_cnt;
   logic        mon_en = 1'b0;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string n, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", n, act, exp);
      end
   endtask

   // One cycle of stimulus for the next rising edge, plus the model update.
   task automatic step(input logic v, input logic [31:0] a,
                       input logic rr, input logic fl, input logic le,
                       input logic [7:0] la, input logic [31:0] ld,
                       output logic acc);
      ent_t e;
      @(posedge clk);
      #1;
      bus.req_valid = v;
      bus.req_addr  = a;
      bus.rsp_ready = rr;
      flush         = fl;
      ld_en         = le;
      ld_addr       = la;
      ld_data       = ld;
      exp_valid = (q.size() != 0);
      exp_ready = (q.size() != 2) && !fl;
      exp_cnt   = cnt_model;
      mon_en    = 1'b1;
      acc       = v && exp_ready;
      e.addr  = a;
      e.err   = {a[31:2] >= DEPTH, a[1:0] != 2'b00};
      if (e.err != 2'b00)
         e.instr = NOP;
      else if (le && (32'(la) == 32'(a[31:2])))
         e.instr = ld;
      else
         e.instr = mm[a[31:2]];
      if (acc) begin
         q.push_back(e);
         cnt_model = cnt_model + 1;
      end
      if (fl) q.delete();
      if (le && (int'(la) < DEPTH)) mm[la] = ld;
   endtask

   task automatic req(input logic [31:0] a, input logic rr,
                      output logic acc);
      step(1'b1, a, rr, 1'b0, 1'b0, 8'd0, 32'd0, acc);
   endtask

   task automatic idle(input logic rr);
      logic acc;
      step(1'b0, 32'd0, rr, 1'b0, 1'b0, 8'd0, 32'd0, acc);
   endtask

   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
         chk("rsp_valid", 32'(bus.rsp_valid), 32'(exp_valid));
         chk("fetch_cnt", fetch_cnt, exp_cnt);
         if (bus.rsp_valid && bus.rsp_ready && !flush) begin
            if (q.size() == 0) begin
               chk("unexpected_rsp", 32'(bus.rsp_addr), 32'hFFFF_FFFF);
            end else begin
               ent_t e;
               e = q.pop_front();
               chk("rsp_instr", bus.rsp_instr, e.instr);
               chk("rsp_addr", bus.rsp_addr, e.addr);
               chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            end
         end
      end
   end

   initial begin
      logic acc;
      cnt_model     = 0;
      bus.req_valid = 1'b0;
      bus.req_addr  = 32'd0;
      bus.rsp_ready = 1'b0;
      flush         = 1'b0;
      ld_en         = 1'b0;
      ld_addr       = '0;
      ld_data       = 32'd0;
      rst_n         = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_instr", bus.rsp_instr, 32'd0);
      chk("rst_addr", bus.rsp_addr, 32'd0);
      chk("rst_err", 32'(bus.rsp_err), 32'd0);
      chk("rst_cnt", fetch_cnt, 32'd0);
      #10 rst_n = 1'b1;

      // Program image through the load port.
      for (int i = 0; i < DEPTH; i++)
         step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 8'(i), $urandom, acc);

      // Back-to-back fetch of words 0,1,2.
      req(32'h0, 1'b1, acc);
      req(32'h4, 1'b1, acc);
      req(32'h8, 1'b1, acc);
      idle(1'b1);
      idle(1'b1);

      // Back-pressure: two accepted, third held until space.
      req(32'h10, 1'b0, acc);
      req(32'h14, 1'b0, acc);
      req(32'h18, 1'b0, acc);
      chk("bp_third_blocked", 32'(acc), 32'd0);
      acc = 1'b0;
      for (int i = 0; i < 5 && !acc; i++) req(32'h18, 1'b1, acc);
      chk("bp_third_accepted", 32'(acc), 32'd1);
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);

      // Misaligned and out-of-range requests.
      req(32'h6, 1'b1, acc);
      req(32'(DEPTH * 4), 1'b1, acc);
      idle(1'b1);
      idle(1'b1);

      // Flush with two buffered and a live request.
      req(32'h20, 1'b0, acc);
      req(32'h24, 1'b0, acc);
      step(1'b1, 32'h28, 1'b1, 1'b1, 1'b0, 8'd0, 32'd0, acc);
      chk("flush_blocks_req", 32'(acc), 32'd0);
      idle(1'b1);
      idle(1'b1);

      // Same-cycle load and fetch of word 5.
      step(1'b1, 32'h14, 1'b1, 1'b0, 1'b1, 8'd5, 32'hDEAD_BEEF, acc);
      idle(1'b1);
      idle(1'b1);

      // Reset with one entry buffered; memory must survive.
      req(32'h30, 1'b0, acc);
      idle(1'b0);
      @(posedge clk);
      #3;
      mon_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mid_rst_instr", bus.rsp_instr, 32'd0);
      chk("mid_rst_addr", bus.rsp_addr, 32'd0);
      chk("mid_rst_cnt", fetch_cnt, 32'd0);
      q.delete();
      cnt_model = 0;
      #2 rst_n = 1'b1;
      req(32'h30, 1'b1, acc);
      idle(1'b1);
      idle(1'b1);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] a;
         logic [7:0]  la;
         logic        le;
         int          r;
         r = $urandom_range(0, 9);
         if (r < 7)      a = {22'd0, 8'($urandom_range(0, DEPTH - 1)), 2'b00};
         else if (r == 7) a = {22'd0, 8'($urandom_range(0, DEPTH - 1)),
                               2'($urandom_range(1, 3))};
         else if (r == 8) a = 32'($urandom_range(DEPTH, 400)) << 2;
         else             a = $urandom;
         le = ($urandom_range(0, 5) == 0);
         la = 8'($urandom_range(0, 255));
         if (le && $urandom_range(0, 1) == 1) la = a[9:2];
         step($urandom_range(0, 3) != 0, a, $urandom_range(0, 2) != 0,
              $urandom_range(0, 24) == 0, le, la, $urandom, acc);
      end

      // Drain the buffer.
      for (int i = 0; i < 10 && q.size() != 0; i++) idle(1'b1);
      @(negedge clk);
      #1;
      chk("drain_empty", 32'(q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
